// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game blocks: FSM state encoding, button
// count, colour one-hot codes and the last round-timer count.
package genius_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int N_BTN = 4;

    localparam logic [N_BTN-1:0] GREEN  = 4'b0001;
    localparam logic [N_BTN-1:0] RED    = 4'b0010;
    localparam logic [N_BTN-1:0] YELLOW = 4'b0100;
    localparam logic [N_BTN-1:0] BLUE   = 4'b1000;

    localparam int TIMER_LAST = 9;

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts 0..DIV-1 while clr is low and emits a registered one-cycle
// tick during the cycle in which the count sits at DIV-1.
module tick_div #(
    parameter int DIV = 50_000_000
) (
    input  logic CLK1,
    input  logic R,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Tick is decoded one count early so it lines up with count DIV-1.
    always_ff @(posedge CLK1) begin
        if (R || clr) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == CNT_PRE);
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/genius_input_fsm.sv
// Player-input window supervisor: opens a timed window on start, drives the
// round timer, and reports exactly one of hit, miss or timeout per window.
module genius_input_fsm #(
    parameter int TICK_DIV = 50_000_000,
    parameter int N_BTN    = genius_pkg::N_BTN
) (
    input  logic             CLK1,
    input  logic             R,
    input  logic             start,
    input  logic [N_BTN-1:0] expected,
    input  logic [N_BTN-1:0] btn,
    input  logic             end_time,
    output logic             timer_R,
    output logic             timer_E,
    output logic             busy,
    output logic             hit,
    output logic             miss,
    output logic             timeout,
    output logic [N_BTN-1:0] last_btn
);

    import genius_pkg::*;

    state_t           state_r, state_nxt_s;
    logic [N_BTN-1:0] btn_q_r, exp_r, exp_nxt_s, last_btn_r, last_btn_nxt_s;
    logic [N_BTN-1:0] press_s;
    logic             hit_s, miss_s, timeout_s, pre_clr_s;
    logic             tmr_clr_r, busy_r, hit_r, miss_r, timeout_r;

    assign press_s = btn & ~btn_q_r;

    // Next-state and decision logic; a press outranks a simultaneous expiry.
    always_comb begin
        state_nxt_s    = state_r;
        exp_nxt_s      = exp_r;
        last_btn_nxt_s = last_btn_r;
        hit_s          = 1'b0;
        miss_s         = 1'b0;
        timeout_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WAIT;
                    exp_nxt_s   = expected;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (press_s != {N_BTN{1'b0}}) begin
                    if (press_s == exp_r) begin
                        hit_s = 1'b1;
                    end else begin
                        miss_s = 1'b1;
                    end
                    last_btn_nxt_s = press_s;
                    state_nxt_s    = ST_RELEASE;
                end else if (end_time) begin
                    timeout_s      = 1'b1;
                    last_btn_nxt_s = {N_BTN{1'b0}};
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RELEASE: begin
                if (btn == {N_BTN{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Prescaler only runs while the window stays open, so it is zero on entry
    // and its tick is already gone in the cycle after a decision.
    assign pre_clr_s = (state_r != ST_WAIT) || (state_nxt_s != ST_WAIT);

    tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .CLK1 (CLK1),
        .R    (R),
        .clr  (pre_clr_s),
        .tick (timer_E)
    );

    // State, button history and registered outputs.
    always_ff @(posedge CLK1) begin
        if (R) begin
            state_r    <= ST_IDLE;
            btn_q_r    <= {N_BTN{1'b0}};
            exp_r      <= {N_BTN{1'b0}};
            last_btn_r <= {N_BTN{1'b0}};
            tmr_clr_r  <= 1'b1;
            busy_r     <= 1'b0;
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            btn_q_r    <= btn;
            exp_r      <= exp_nxt_s;
            last_btn_r <= last_btn_nxt_s;
            tmr_clr_r  <= (state_nxt_s != ST_WAIT);
            busy_r     <= (state_nxt_s != ST_IDLE);
            hit_r      <= hit_s;
            miss_r     <= miss_s;
            timeout_r  <= timeout_s;
        end
    end

    assign timer_R  = tmr_clr_r;
    assign busy     = busy_r;
    assign hit      = hit_r;
    assign miss     = miss_r;
    assign timeout  = timeout_r;
    assign last_btn = last_btn_r;

endmodule

// File: tb/tb_genius_input_fsm.sv
// Directed bench for genius_input_fsm with TICK_DIV=4 and a behavioural model
// of the 0..9 round timer closing the end_time loop.
module tb_genius_input_fsm;

    logic       CLK1 = 1'b0;
    logic       R = 1'b1;
    logic       start = 1'b0;
    logic [3:0] expected = 4'b0000;
    logic [3:0] btn = 4'b0000;
    logic       end_time;
    logic       timer_R, timer_E, busy, hit, miss, timeout;
    logic [3:0] last_btn;
    logic [3:0] tmr_cnt = 4'd0;
    int         checks = 0;
    int         failures = 0;

    genius_input_fsm #(.TICK_DIV(4), .N_BTN(4)) dut (
        .CLK1(CLK1), .R(R), .start(start), .expected(expected), .btn(btn),
        .end_time(end_time), .timer_R(timer_R), .timer_E(timer_E), .busy(busy),
        .hit(hit), .miss(miss), .timeout(timeout), .last_btn(last_btn)
    );

    always #5 CLK1 = ~CLK1;

    // Round timer model: cleared by timer_R, counts ticks up to 9.
    always @(posedge CLK1) begin
        if (timer_R === 1'b1) tmr_cnt <= 4'd0;
        else if (timer_E === 1'b1 && tmr_cnt != 4'd9) tmr_cnt <= tmr_cnt + 4'd1;
    end
    assign end_time = (tmr_cnt == 4'd9);

    task automatic step();
        @(posedge CLK1);
        #1;
    endtask

    // Leaves the caller in WAIT index 0.
    task automatic do_start(input logic [3:0] e);
        start = 1'b1;
        expected = e;
        step();
        start = 1'b0;
        expected = 4'b0000;
    endtask

    task automatic test_reset();
        logic [5:0] v;
        R = 1'b1;
        step();
        step();
        v = {timer_R, timer_E, busy, hit, miss, timeout};
        checks++;
        if (v !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outs: got %b expected %b", v, 6'b100000);
        end
        R = 1'b0;
        step();
        v = {timer_R, timer_E, busy, hit, miss, timeout};
        checks++;
        if (v !== 6'b100000 || last_btn !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset: got %b/%b expected 100000/0000", v, last_btn);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] v, e;
        int n_to;
        n_to = 0;
        do_start(4'b0010);
        for (int idx = 0; idx <= 37; idx++) begin
            v = {timer_E, timeout, busy, timer_R};
            if (idx < 37) e = {(idx % 4 == 3), 1'b0, 1'b1, 1'b0};
            else e = 4'b0101;
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL timeout_idx%0d: got %b expected %b (tE,to,busy,tR)", idx, v, e);
            end
            if (timeout === 1'b1) n_to++;
            if (idx < 37) step();
        end
        checks++;
        if (last_btn !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_last_btn: got %b expected 0000", last_btn);
        end
        step();
        if (timeout === 1'b1) n_to++;
        checks++;
        if (n_to != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_once: got count=%0d busy=%b expected count=1 busy=0", n_to, busy);
        end
    endtask

    task automatic test_hit();
        do_start(4'b0100);
        for (int i = 0; i < 10; i++) step();
        btn = 4'b0100;
        step();
        checks++;
        if ({hit, miss, timeout, timer_E, timer_R, busy} !== 6'b100011 || last_btn !== 4'b0100) begin
            failures++;
            $display("FAIL hit_pulse: got %b/%b expected 100011/0100",
                     {hit, miss, timeout, timer_E, timer_R, busy}, last_btn);
        end
        step();
        step();
        checks++;
        if (hit !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hit_release_hold: got hit=%b busy=%b expected hit=0 busy=1", hit, busy);
        end
        btn = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL hit_busy_drop: got %b expected 0", busy);
        end
    endtask

    task automatic test_miss(input logic [3:0] press_v);
        do_start(4'b0001);
        for (int i = 0; i < 5; i++) step();
        btn = press_v;
        step();
        checks++;
        if ({hit, miss, timeout} !== 3'b010 || last_btn !== press_v) begin
            failures++;
            $display("FAIL miss_%b: got %b/%b expected 010/%b", press_v, {hit, miss, timeout}, last_btn, press_v);
        end
        btn = 4'b0000;
        step();
        step();
    endtask

    task automatic test_held_button();
        int pulses;
        pulses = 0;
        btn = 4'b0001;
        step();
        step();
        do_start(4'b0001);
        for (int idx = 0; idx < 12; idx++) begin
            if (idx == 8) btn = 4'b0000;
            if (hit === 1'b1 || miss === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL held_no_pulse: got %0d pulses expected 0", pulses);
        end
        btn = 4'b0001;
        step();
        checks++;
        if (hit !== 1'b1 || last_btn !== 4'b0001) begin
            failures++;
            $display("FAIL held_repress_hit: got hit=%b last=%b expected hit=1 last=0001", hit, last_btn);
        end
        btn = 4'b0000;
        step();
        step();
    endtask

    task automatic test_simultaneous();
        int n_to;
        n_to = 0;
        do_start(4'b1000);
        for (int i = 0; i < 36; i++) step();
        btn = 4'b1000;
        step();
        checks++;
        if ({hit, miss, timeout} !== 3'b100) begin
            failures++;
            $display("FAIL press_at_expiry: got %b expected 100 (hit,miss,to)", {hit, miss, timeout});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (timeout === 1'b1) n_to++;
        end
        btn = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            if (timeout === 1'b1) n_to++;
        end
        checks++;
        if (n_to != 0) begin
            failures++;
            $display("FAIL no_late_timeout: got %0d expected 0", n_to);
        end
    endtask

    task automatic test_reset_mid();
        do_start(4'b0100);
        for (int i = 0; i < 20; i++) step();
        R = 1'b1;
        step();
        R = 1'b0;
        checks++;
        if ({timer_R, timer_E, busy, hit, miss, timeout} !== 6'b100000 || last_btn !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid: got %b/%b expected 100000/0000",
                     {timer_R, timer_E, busy, hit, miss, timeout}, last_btn);
        end
        step();
        checks++;
        if ({busy, hit, miss, timeout} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_after: got %b expected 0000", {busy, hit, miss, timeout});
        end
    endtask

    task automatic test_start_ignored();
        do_start(4'b0010);
        for (int i = 0; i < 4; i++) step();
        start = 1'b1;
        expected = 4'b0100;
        step();
        start = 1'b0;
        expected = 4'b0000;
        step();
        step();
        checks++;
        if (timer_E !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_wait_tick: got tE=%b busy=%b expected tE=1 busy=1", timer_E, busy);
        end
        step();
        btn = 4'b0010;
        step();
        checks++;
        if ({hit, miss} !== 2'b10) begin
            failures++;
            $display("FAIL start_in_wait_expected: got %b expected 10 (hit,miss)", {hit, miss});
        end
        start = 1'b1;
        expected = 4'b0001;
        step();
        start = 1'b0;
        expected = 4'b0000;
        btn = 4'b0000;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || timer_R !== 1'b1) begin
                failures++;
                $display("FAIL start_in_release_queued: got busy=%b tR=%b expected busy=0 tR=1", busy, timer_R);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_hit();
        test_miss(4'b0011);
        test_miss(4'b1000);
        test_held_button();
        test_simultaneous();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
